mux_rr_arbiter: RTL

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_arb_pkg.sv | 13 +
 rtl/mux_rr_arbiter_mux4.sv | 13 +
 rtl/mux_rr_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and sizing for the round-robin mux arbiter.
// Optional burst limit is enabled by defining MUX_ARB_BURST_LIMIT_EN.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux_rr_arbiter_mux4.sv
// Plain 4:1 single-bit datapath mux driven by the arbiter select.
// Not affected by MUX_ARB_BURST_LIMIT_EN.
module mux4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] in,
    input  logic [SEL_W-1:0]   sel,
    output logic               out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering a 4:1 mux, grants registered one cycle after req.
// Define MUX_ARB_BURST_LIMIT_EN to cap each owner at MAX_BURST consecutive cycles.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] in,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               valid,
    output logic               out
);

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("MAX_BURST out of range 1..15");
    end

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   last_q;
    logic               valid_q;
    logic               mux_out;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [SEL_W-1:0]   scan_idx;
    logic               keep;

    // Search begins one past the last owner and wraps back to it.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_q;
        scan_idx   = last_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = last_q + SEL_W'(i);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

`ifdef MUX_ARB_BURST_LIMIT_EN
    logic [3:0] cnt_q;
    logic       burst_done;
    logic       others;

    assign burst_done = (cnt_q == 4'(MAX_BURST - 1));
    assign others     = |(req & ~gnt_q);
    assign keep       = req[sel_q] && !(burst_done && others);
`else
    assign keep = req[sel_q];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= SEL_W'(NUM_REQ - 1);
`ifdef MUX_ARB_BURST_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else if (state_q == GRANT && keep) begin
`ifdef MUX_ARB_BURST_LIMIT_EN
            if (burst_done) begin
                cnt_q <= '0;
            end else if (cnt_q != 4'hF) begin
                cnt_q <= cnt_q + 4'd1;
            end
`endif
        end else if (pick_found) begin
            state_q <= GRANT;
            gnt_q   <= NUM_REQ'(1) << pick_idx;
            sel_q   <= pick_idx;
            valid_q <= 1'b1;
            last_q  <= pick_idx;
`ifdef MUX_ARB_BURST_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end
    end

    mux4 u_mux (
        .in  (in),
        .sel (sel_q),
        .out (mux_out)
    );

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign out   = valid_q & mux_out;

endmodule
